// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buf.sv
// Shift-register FIFO of {pc, inst} entries; slot 0 is the registered head.
module fetch_buf
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   wr_idx;
    logic            do_push;
    logic            do_pop;

    assign count   = cnt;
    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign wr_idx  = do_pop ? IW'(cnt - CW'(1)) : IW'(cnt);
    assign head    = mem[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            cnt <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (do_push) begin
                mem[wr_idx] <= wdata;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding memory request, buffered output to the decoder,
// and redirect handling that discards in-flight responses.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready
);

    localparam int CW  = $clog2(BUF_DEPTH + 1);
    localparam int CW1 = CW + 1;

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] addr_q;
    logic              issue;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              room_after;
    logic [CW-1:0]     count;
    fetch_entry_t      head;
    fetch_entry_t      wentry;

    assign pc_inc     = pc + 32'd4;
    assign pop        = inst_ready && !empty;
    assign room_after = (CW1'(count) + CW1'(1) - CW1'(pop)) < CW1'(BUF_DEPTH);
    assign wentry     = '{pc: addr_q, inst: imem_rdata};

    assign imem_req   = (state != IDLE);
    assign imem_addr  = addr_q;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign inst_valid = !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect_valid && !full) begin
                    next_state = WAIT;
                    issue      = 1'b1;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        next_state = IDLE;
                    end else begin
                        push = 1'b1;
                        if (room_after) begin
                            next_state = WAIT;
                            issue      = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end else if (redirect_valid) begin
                    next_state = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // pc always names the next word to fetch; addr_q holds the address on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC & ~ADDR_W'(3);
            addr_q <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc & ~ADDR_W'(3);
            end else if (push) begin
                pc <= pc_inc;
            end
            if (issue) begin
                addr_q <= push ? pc_inc : pc;
            end
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wentry),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; the only supported values are 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits [1:0] are always 0.
REQ-007 imem_ack  input  1  memory response valid; meaningful only while imem_req=1.
REQ-008 imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-009 redirect_valid  input  1  single-cycle flush and new-PC strobe from branch/jump logic.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-011 inst  output  32  instruction word presented to the control decoder.
REQ-012 inst_pc  output  32  address of inst.
REQ-013 inst_valid  output  1  inst and inst_pc hold a valid instruction.
REQ-014 inst_ready  input  1  decoder accepts inst; transfer occurs when inst_valid=1 and inst_ready=1.

Function
REQ-015 FSM states: IDLE (no request outstanding), WAIT (request outstanding, response kept), DROP (request outstanding, response discarded).
REQ-016 IDLE->WAIT when occupancy+0 < BUF_DEPTH and redirect_valid=0; imem_req asserts in the same cycle and imem_addr=pc.
REQ-017 In WAIT/DROP, imem_req stays 1 and imem_addr stays stable until the cycle with imem_ack=1.
REQ-018 WAIT with imem_ack=1: {pc_of_request, imem_rdata} is written to the buffer and pc advances by 4 (wrap 32'hFFFF_FFFC -> 0); next state is WAIT with a new request if space remains after the write and pop, otherwise IDLE.
REQ-019 At most one request is outstanding; a request is issued only when the buffer has a free entry that is not reserved by the in-flight response.
REQ-020 inst/inst_pc/inst_valid are driven from the buffer head register, never combinationally from imem_rdata; minimum latency from imem_ack to inst_valid is 1 cycle.
REQ-021 inst, inst_pc, and inst_valid stay stable while inst_valid=1 and inst_ready=0.
REQ-022 A buffer write and a head pop may occur in the same cycle when the buffer is full; occupancy is unchanged.
REQ-023 redirect_valid=1: the buffer is flushed (inst_valid=0 next cycle), and pc<=redirect_pc&~3.
REQ-024 Redirect in WAIT without imem_ack: next state is DROP; the pending response is discarded.
REQ-025 Redirect in the same cycle as imem_ack (WAIT or DROP): the response is discarded, and the next state is IDLE, which issues redirect_pc on the following cycle.
REQ-026 DROP with imem_ack=1 and no redirect: the data is discarded, pc is not advanced, and the next state is IDLE.
REQ-027 Redirect while in DROP: pc is updated, and the state remains DROP.
REQ-028 Redirect has priority over a simultaneous pop; the popped entry counts as consumed by the decoder.

Reset
REQ-029 While rst_n=0: pc=RESET_PC, state=IDLE, buffer empty, imem_req=0, imem_addr=0, inst=0, inst_pc=0, inst_valid=0.
REQ-030 Reset assertion mid-request abandons the request; the memory side tolerates imem_req dropping without ack.
REQ-031 The first imem_req=1 occurs in the first rising edge after rst_n deasserts, with imem_addr=RESET_PC.

Structure
REQ-032 The shared package holds the fetch-state enum (IDLE/WAIT/DROP), the RESET_PC default, and the INST_W=32/ADDR_W=32 constants.
REQ-033 The buffer is one sub-module, fetch_buf: a synchronous FIFO of {pc[31:0], inst[31:0]} with push, pop, flush, full, empty, and a registered head.

Verification
REQ-034 Reset release, memory acks every request next cycle, inst_ready=1 -> imem_addr 0,4,8,...; inst_pc 0,4,8 with inst_valid first high 2 cycles after rst_n rise and continuous thereafter.
REQ-035 inst_ready=0 for 10 cycles -> exactly BUF_DEPTH entries are buffered, imem_req=0 afterward, inst/inst_pc are frozen, and no instruction is lost or duplicated on release.
REQ-036 Redirect to 32'h0000_0103 while a request for 0x10 is outstanding, with ack 3 cycles later -> the 0x10 data is never presented, the next imem_addr is 0x100, and the next inst_pc is 0x100.
REQ-037 redirect_valid and imem_ack in the same cycle -> the acked data is dropped, inst_valid=0 next cycle, and the next request address equals redirect_pc.
REQ-038 rst_n pulsed low mid-WAIT with ack arriving after release -> all outputs are reset values during reset, and the restart fetches from RESET_PC with no stale instruction.
REQ-039 pc at 32'hFFFF_FFFC acked -> next imem_addr=0, and inst_pc sequence FFFF_FFFC then 0000_0000.
